// File: rtl/delay_line.sv
// Runtime-programmable delay line (0..MAX_DLY cycles) with per-stage valid, stall, flush and retune invalidation.
// Optional per-stage even parity and o_par_err output when DELAY_LINE_PARITY_EN is defined.
`timescale 1ns/1ps
module delay_line #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_DLY = 16,
    parameter int unsigned DLY_W   = 5,
    parameter int unsigned RST_DLY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_flush,
    input  logic [DLY_W-1:0]  iv_dly,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] iv_data,
    output logic              o_vld,
    output logic [DATA_W-1:0] ov_data,
    output logic              o_dly_err
`ifdef DELAY_LINE_PARITY_EN
    ,
    output logic              o_par_err
`endif
);

    logic [DATA_W-1:0]  stg_data [MAX_DLY];
    logic [MAX_DLY-1:0] stg_vld;
    logic [DLY_W-1:0]   r_dly;
    logic [DLY_W-1:0]   eff_dly_c;
    logic               dly_over_c;
    logic               dly_chg_c;
    logic               shift_c;
    logic               tap_vld_c;
    logic [DATA_W-1:0]  tap_data_c;

    // Requested delay is clamped to the physical depth; any change retunes the tap.
    always_comb begin
        dly_over_c = (iv_dly > DLY_W'(MAX_DLY));
        eff_dly_c  = dly_over_c ? DLY_W'(MAX_DLY) : iv_dly;
        dly_chg_c  = (eff_dly_c != r_dly);
        shift_c    = i_en && !i_flush && !dly_chg_c;
    end

    // Delay select, error flag and valid flags; flush and retune both kill every valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dly     <= DLY_W'(RST_DLY);
            o_dly_err <= 1'b0;
            stg_vld   <= '0;
        end else begin
            r_dly     <= eff_dly_c;
            o_dly_err <= dly_over_c;
            if (i_flush || dly_chg_c) begin
                stg_vld <= '0;
            end else if (i_en) begin
                stg_vld[0] <= i_vld;
                for (int k = 1; k < int'(MAX_DLY); k++) begin
                    stg_vld[k] <= stg_vld[k-1];
                end
            end
        end
    end

    // Sample data shifts only on a plain enabled edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < int'(MAX_DLY); k++) begin
                stg_data[k] <= '0;
            end
        end else if (shift_c) begin
            stg_data[0] <= iv_data;
            for (int k = 1; k < int'(MAX_DLY); k++) begin
                stg_data[k] <= stg_data[k-1];
            end
        end
    end

    // Tap select: stage r_dly-1 holds a sample loaded r_dly enabled edges ago.
    always_comb begin
        tap_vld_c  = 1'b0;
        tap_data_c = '0;
        for (int k = 0; k < int'(MAX_DLY); k++) begin
            if (r_dly == DLY_W'(k + 1)) begin
                tap_vld_c  = stg_vld[k];
                tap_data_c = stg_data[k];
            end
        end
    end

    // Zero delay is a straight combinational bypass.
    always_comb begin
        if (r_dly == '0) begin
            o_vld   = i_vld;
            ov_data = iv_data;
        end else begin
            o_vld   = tap_vld_c;
            ov_data = tap_data_c;
        end
    end

`ifdef DELAY_LINE_PARITY_EN
    logic [MAX_DLY-1:0] stg_par;
    logic               tap_par_c;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stg_par <= '0;
        end else if (shift_c) begin
            stg_par[0] <= ^iv_data;
            for (int k = 1; k < int'(MAX_DLY); k++) begin
                stg_par[k] <= stg_par[k-1];
            end
        end
    end

    always_comb begin
        tap_par_c = 1'b0;
        for (int k = 0; k < int'(MAX_DLY); k++) begin
            if (r_dly == DLY_W'(k + 1)) begin
                tap_par_c = stg_par[k];
            end
        end
    end

    // Bypass carries no stored parity, so it can never flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_par_err <= 1'b0;
        end else begin
            o_par_err <= (r_dly != '0) && tap_vld_c && (tap_par_c != (^tap_data_c));
        end
    end
`endif

endmodule

// File: tb/tb_delay_line.sv
// Directed bench for delay_line: reset, depth, bypass/clamp, retune, stall, flush, async reset.
`timescale 1ns/1ps
module tb_delay_line;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_en;
    logic       i_flush;
    logic [4:0] iv_dly;
    logic       i_vld;
    logic [7:0] iv_data;
    logic       o_vld;
    logic [7:0] ov_data;
    logic       o_dly_err;

    int n_tests = 0;
    int n_fail  = 0;

    delay_line #(
        .DATA_W (8),
        .MAX_DLY(16),
        .DLY_W  (5),
        .RST_DLY(2)
    ) u_dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (i_en),
        .i_flush  (i_flush),
        .iv_dly   (iv_dly),
        .i_vld    (i_vld),
        .iv_data  (iv_data),
        .o_vld    (o_vld),
        .ov_data  (ov_data),
        .o_dly_err(o_dly_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        i_vld   = v;
        iv_data = d;
        tick();
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_en    = 1'b1;
        i_flush = 1'b0;
        iv_dly  = 5'd2;
        i_vld   = 1'b0;
        iv_data = 8'h00;

        // Reset and default delay of 2
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_out", {o_vld, ov_data}, 9'h000);
        check("rst_err", o_dly_err, 1'b0);
        i_rst_n = 1'b1;
        drive(1'b1, 8'h11);
        check("d2_e1", o_vld, 1'b0);
        drive(1'b1, 8'h22);
        check("d2_e2", {o_vld, ov_data}, 9'h111);
        drive(1'b1, 8'h33);
        check("d2_e3", {o_vld, ov_data}, 9'h122);
        drive(1'b0, 8'h00);
        check("d2_e4", {o_vld, ov_data}, 9'h133);
        drive(1'b0, 8'h00);
        check("d2_e5", o_vld, 1'b0);

        // Full depth 16
        iv_dly = 5'd16;
        drive(1'b0, 8'h00);
        for (int j = 1; j <= 17; j++) begin
            drive(1'b1, 8'(j - 1));
            if (j == 15) check("d16_e15", o_vld, 1'b0);
            if (j == 16) check("d16_e16", {o_vld, ov_data}, 9'h100);
            if (j == 17) check("d16_e17", {o_vld, ov_data}, 9'h101);
        end

        // Depth 1
        iv_dly = 5'd1;
        drive(1'b0, 8'h00);
        drive(1'b1, 8'hA5);
        check("d1_e1", {o_vld, ov_data}, 9'h1A5);
        drive(1'b0, 8'h00);
        check("d1_e2", o_vld, 1'b0);

        // Bypass
        iv_dly = 5'd0;
        drive(1'b0, 8'h00);
        i_vld   = 1'b1;
        iv_data = 8'h3C;
        #1;
        check("byp_a", {o_vld, ov_data}, 9'h13C);
        i_vld   = 1'b0;
        iv_data = 8'h5A;
        #1;
        check("byp_b", {o_vld, ov_data}, 9'h05A);

        // Clamp 20 -> 16
        iv_dly = 5'd20;
        check("clamp_err_pre", o_dly_err, 1'b0);
        drive(1'b0, 8'h00);
        check("clamp_err", o_dly_err, 1'b1);
        for (int j = 1; j <= 16; j++) begin
            drive(1'b1, 8'(8'h80 + j));
            if (j == 15) check("clamp_e15", o_vld, 1'b0);
            if (j == 16) check("clamp_e16", {o_vld, ov_data}, 9'h181);
        end
        check("clamp_err_hold", o_dly_err, 1'b1);

        // Retune 4 -> 6 mid-stream
        iv_dly = 5'd4;
        drive(1'b0, 8'h00);
        check("d4_err_clr", o_dly_err, 1'b0);
        for (int j = 1; j <= 6; j++) begin
            drive(1'b1, 8'(8'h40 + j));
            if (j == 4) check("d4_e4", {o_vld, ov_data}, 9'h141);
            if (j == 6) check("d4_e6", {o_vld, ov_data}, 9'h143);
        end
        iv_dly = 5'd6;
        for (int j = 7; j <= 14; j++) begin
            drive(1'b1, 8'(8'h40 + j));
            if (j <= 12) check($sformatf("chg_stale_%0d", j), o_vld, 1'b0);
            if (j == 13) check("chg_first", {o_vld, ov_data}, 9'h148);
            if (j == 14) check("chg_next", {o_vld, ov_data}, 9'h149);
        end

        // Stall for 5 cycles with junk on the input
        i_en = 1'b0;
        for (int s = 0; s < 5; s++) begin
            drive(1'b1, 8'hEE);
            check($sformatf("stall_%0d", s), {o_vld, ov_data}, 9'h149);
        end
        i_en = 1'b1;
        drive(1'b1, 8'h4F);
        check("resume_a", {o_vld, ov_data}, 9'h14A);
        drive(1'b1, 8'h50);
        check("resume_b", {o_vld, ov_data}, 9'h14B);

        // Flush: the sample at the flush edge is dropped too
        i_flush = 1'b1;
        drive(1'b1, 8'h51);
        check("flush_0", o_vld, 1'b0);
        i_flush = 1'b0;
        for (int j = 18; j <= 23; j++) begin
            drive(1'b1, 8'(8'h40 + j));
            if (j == 22) check("flush_e22", o_vld, 1'b0);
            if (j == 23) check("flush_e23", {o_vld, ov_data}, 9'h152);
        end

        // Async reset between edges
        check("pre_arst", o_vld, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_out", {o_vld, ov_data}, 9'h000);
        iv_dly = 5'd2;
        i_vld  = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(1'b1, 8'h77);
        check("arst_d2_e1", o_vld, 1'b0);
        drive(1'b0, 8'h00);
        check("arst_d2_e2", {o_vld, ov_data}, 9'h177);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_line.md
Name: delay_line

Overview:
- Parametrised, runtime-programmable delay line for DATA_W-bit samples with a per-stage valid flag.
- Generalises the fixed two-register delay. Adds a selectable delay of 0..MAX_DLY, clock-enable stall, synchronous flush and delay-change invalidation.
- Sits in the datapath wherever streams need cycle alignment, for example channel skew compensation ahead of a combiner.

Parameters:
- DATA_W, 8, sample width in bits.
- MAX_DLY, 16, number of physical stages and the largest supported delay (≥1).
- DLY_W, 5, width of the delay select. Must hold MAX_DLY+1.
- RST_DLY, 2, delay in force after reset (≤MAX_DLY).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_en  in  1  advance enable. When low, the pipeline holds.
- i_flush  in  1  synchronous clear of all valid flags.
- iv_dly  in  DLY_W  requested delay, in clock edges.
- i_vld  in  1  input sample valid.
- iv_data  in  DATA_W  input sample.
- o_vld  out  1  output sample valid.
- ov_data  out  DATA_W  delayed sample.
- o_dly_err  out  1  registered flag: the last sampled iv_dly exceeded MAX_DLY.

Behaviour:
- Reset is asynchronous, active-low on i_rst_n; the block is clocked on i_clk.
- During reset:
  - all stage data = 0 and all stage valid = 0;
  - active delay register r_dly = RST_DLY;
  - o_dly_err = 0.
  - Consequently ov_data = 0 and o_vld = 0 (when RST_DLY ≥ 1).
- Delay select:
  - iv_dly is sampled every edge, independent of i_en.
  - eff = min(iv_dly, MAX_DLY).
  - o_dly_err <= (iv_dly > MAX_DLY) on every edge.
- Delay change: on an edge where eff != r_dly:
  - r_dly <= eff;
  - all valid flags are cleared, and the input sample at that edge is also discarded (stage0 valid = 0);
  - data registers are not required to clear.
  - The new tap is used from the following cycle.
- Shift, on an edge with i_en = 1 and no flush or delay change:
  - stage[0] <= {i_vld, iv_data};
  - stage[k] <= stage[k-1] for k = 1..MAX_DLY-1.
- Stall: with i_en = 0, all stages hold, and the outputs hold their tap value.
- Output tap:
  - r_dly = N ≥ 1: {o_vld, ov_data} = stage[N-1]. A sample accepted on enabled edge k appears after edge k+N-1, i.e. N enabled edges of latency. N = 2 reproduces the legacy two-register delay.
  - r_dly = 0: combinational bypass, ov_data = iv_data and o_vld = i_vld.
- Flush: i_flush = 1 at an edge clears all valid flags, including stage[0], regardless of i_en. Data registers are untouched.
- Priority: reset > flush = delay change (both only clear valids; r_dly still updates on a change during flush) > i_en shift.
- Invalid stages keep propagating their data bits, but o_vld = 0 marks them don't-care.
- Reset mid-stream discards all in-flight samples immediately and returns r_dly to RST_DLY.

Optional Feature:
- Macro: DELAY_LINE_PARITY_EN.
- With the macro defined:
  - each stage carries an extra even-parity bit computed from iv_data at stage[0] load;
  - adds output o_par_err (1 bit, registered, reset 0), set for one cycle when the tapped stage is valid and its stored parity mismatches its data;
  - parity propagates, holds and flushes exactly like data.
- Without the macro: no parity storage, and port o_par_err does not exist.

Test Plan:
- Reset and default: hold i_rst_n = 0 for 3 cycles, then release with iv_dly = 2, i_en = 1. Feed iv_data = 0x11, 0x22, 0x33 with i_vld = 1 on consecutive edges → after reset ov_data = 0x00, o_vld = 0. 0x11 appears with o_vld = 1 after the 2nd edge following its load, then 0x22 and 0x33 on successive cycles.
- Programmable depth: iv_dly = 16 with an incrementing stream 0x00.. → first o_vld = 1 exactly 16 edges after the first valid input, ov_data = 0x00. Repeat with iv_dly = 1 → 1-edge latency.
- Bypass and clamp:
  - iv_dly = 0 → ov_data follows iv_data in the same cycle.
  - iv_dly = 20 (MAX_DLY = 16) → o_dly_err = 1 from the next edge, and latency = 16.
- Delay change: stream running at delay 4, switch to 6 → o_vld = 0 from the next cycle. The first valid output reappears 6 enabled edges after the first post-change valid input, and no stale sample is marked valid.
- Stall and flush:
  - i_en = 0 for 5 cycles mid-stream → ov_data and o_vld constant, with no sample lost or duplicated after resume.
  - i_flush pulse → o_vld = 0 until new valid data propagates through the full delay.
- Async reset mid-stream: assert i_rst_n = 0 between clock edges while o_vld = 1 → o_vld and ov_data go to 0 immediately (before the next edge), and r_dly returns to 2.
